// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush dominates push.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, credit-limited imem requests, redirect flush with
// in-flight response discard, and a buffered instruction queue toward decode.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   q_count;
  logic            q_full, q_empty;
  fetch_entry_t    q_head, q_push_data;
  logic [CW:0]     in_use;
  logic            req_fire, rsp_keep, consume;

  // Discarded responses still hold credit until they come back.
  assign in_use         = {1'b0, outstanding_q} + {1'b0, q_count};
  assign imem_req_valid = (in_use < (CW + 1)'(QDEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_keep       = imem_rsp_valid & (discard_q == '0) & ~redirect_valid;
  assign consume        = instr_valid & instr_ready;
  assign q_push_data    = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(WORD_BYTES);
    if (rsp_keep) rsp_pc_d = rsp_pc_q + XLEN'(WORD_BYTES);
    if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    // Everything still in flight after this edge belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (rsp_keep),
    .push_data(q_push_data),
    .pop      (consume),
    .flush    (redirect_valid),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign instr_valid = ~q_empty;
  assign instr       = q_empty ? '0 : q_head.instr;
  assign instr_pc    = q_empty ? '0 : q_head.pc;

  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outstanding_q != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    rsp_keep |-> !q_full);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with per-request
// drop tags and a scoreboard mirroring the instruction queue contents.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam int QDEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          drop;
  } mreq_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int          lat;
    bit          rdy_toggle;
    bit          irdy_toggle;
    int          n;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  int          cyc;
  int          lat;
  logic [31:0] exp_fetch_pc;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cons_count;
  int          fire_count;
  logic [31:0] first_pc, last_pc;
  vec_t        vecs[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
    bit    fire, cons, rsp;
    mreq_t m;
    @(negedge clk);
    imem_req_ready = rdy;
    instr_ready    = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp = (mq.size() != 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
    #1;
    chk("req_valid", 32'(imem_req_valid), 32'((mq.size() + sb.size()) < QDEPTH));
    chk("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
    fire = imem_req_valid && rdy;
    if (fire) chk("req_addr", imem_req_addr, exp_fetch_pc);
    cons = instr_valid && irdy;
    if (cons) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %h, none expected", instr_pc);
      end else begin
        chk("instr_pc", instr_pc, sb[0].pc);
        chk("instr", instr, sb[0].ins);
      end
      if (cons_count == 0) first_pc = instr_pc;
      last_pc = instr_pc;
      cons_count++;
    end
    @(posedge clk);
    if (fire) fire_count++;
    if (cons && sb.size() != 0) void'(sb.pop_front());
    if (redir) sb.delete();
    if (rsp) begin
      m = mq.pop_front();
      if (!m.drop && !redir) sb.push_back('{m.addr, mem_word(m.addr)});
    end
    if (redir) foreach (mq[i]) mq[i].drop = 1'b1;
    if (fire) mq.push_back('{exp_fetch_pc, cyc + lat, redir});
    if (redir) exp_fetch_pc = {rpc[31:2], 2'b00};
    else if (fire) exp_fetch_pc = exp_fetch_pc + 32'd4;
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mq.delete();
    sb.delete();
    exp_fetch_pc = 32'h0;
    cyc          = 0;
    repeat (2) @(negedge clk);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1003, 3, 1'b0, 1'b0, 6, 32'h0000_1000, 32'h0000_1014};
    vecs[1] = '{32'h0000_2000, 3, 1'b1, 1'b0, 8, 32'h0000_2000, 32'h0000_201C};
    vecs[2] = '{32'hFFFF_FFF8, 2, 1'b0, 1'b1, 4, 32'hFFFF_FFF8, 32'h0000_0004};
    vecs[3] = '{32'h8000_0010, 1, 1'b1, 1'b1, 5, 32'h8000_0010, 32'h8000_0020};

    // Streaming with a 1-cycle memory.
    do_reset();
    lat = 1; cons_count = 0; fire_count = 0;
    repeat (12) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stream_fires", 32'(fire_count), 32'd12);
    chk("stream_consumed", 32'(cons_count), 32'd10);
    chk("stream_first_pc", first_pc, 32'h0);
    chk("stream_last_pc", last_pc, 32'h24);

    // Decode stalled: credit caps issue at QDEPTH.
    do_reset();
    lat = 1; cons_count = 0; fire_count = 0;
    repeat (10) tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_fires", 32'(fire_count), 32'd4);
    #1;
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    for (int k = 0; k < 20 && cons_count < 4; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_count", 32'(cons_count), 32'd4);
    chk("drain_first_pc", first_pc, 32'h0);
    chk("drain_last_pc", last_pc, 32'hC);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_resumed", 32'(fire_count > 4), 32'd1);

    // Redirect coincident with a request handshake and a response.
    do_reset();
    lat = 1; cons_count = 0; fire_count = 0;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b1, 32'h0000_3000);
    #1;
    chk("redir_req_addr", imem_req_addr, 32'h0000_3000);
    cons_count = 0;
    for (int k = 0; k < 30 && cons_count < 2; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_count", 32'(cons_count), 32'd2);
    chk("redir_first_pc", first_pc, 32'h0000_3000);
    chk("redir_last_pc", last_pc, 32'h0000_3004);

    // Redirect table: in-flight fetches built up, then redirect and drain.
    foreach (vecs[v]) begin
      lat = vecs[v].lat;
      repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, vecs[v].target);
      cons_count = 0;
      for (int k = 0; k < 300 && cons_count < vecs[v].n; k++)
        tick(vecs[v].rdy_toggle ? cyc[0] : 1'b1, vecs[v].irdy_toggle ? ~cyc[0] : 1'b1,
             1'b0, 32'h0);
      chk("vec_count", 32'(cons_count), 32'(vecs[v].n));
      chk("vec_first_pc", first_pc, vecs[v].first);
      chk("vec_last_pc", last_pc, vecs[v].last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
